// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter between the pipeline's instruction-fetch (IF)
// and load/store (LS) request channels and a single-port memory with a fixed
// read latency. A tag pipeline follows every accepted access so that the
// response produced MEM_LATENCY cycles later is routed back to its owner.
//
// Handshake: a request transfers in any cycle where valid && ready are both
// high. Requesters hold their payload stable until accepted. A ready output
// never depends on its own requester's valid, only on the other master's
// valid and the arbitration state.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   if_req_*             fetch request channel (valid/ready/addr)
//   if_flush             drop every fetch response still in flight
//   if_rsp_*             fetch response (valid/data), cannot be stalled
//   ls_req_*             load/store request (valid/ready/we/mask/addr/wdata)
//   ls_rsp_*             load data or store acknowledge (data 0 for stores)
//   mem_*                downstream access, memory always accepts;
//                        mem_rdata valid MEM_LATENCY cycles after a request
module mem_arb #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    input  logic                    if_flush,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic                    ls_req_we,
    input  logic [DATA_WIDTH/8-1:0] ls_req_mask,
    input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
    input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rsp_data,
    output logic                    mem_req_valid,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_mask,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_WIDTH / 8;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
        logic is_write;
    } tag_t;

    logic last_grant_q, last_grant_d;
    logic ls_wins;
    logic if_acc, ls_acc;
    tag_t tag_q [MEM_LATENCY];
    tag_t tag_d [MEM_LATENCY];
    tag_t exit_tag;

    // LS takes a conflict under fixed priority, or in round-robin when IF
    // was the last master served.
    assign ls_wins = (DATA_PRIORITY != 0) || (last_grant_q == OWN_IF);

    // Each ready looks only at the other master's valid, so both are high
    // when idle and exactly one is high during a conflict.
    assign if_req_ready = !ls_req_valid || !ls_wins;
    assign ls_req_ready = !if_req_valid || ls_wins;

    assign if_acc = if_req_valid && if_req_ready;
    assign ls_acc = ls_req_valid && ls_req_ready;

    // Downstream mux
    always_comb begin
        mem_req_valid = if_acc || ls_acc;
        mem_we        = 1'b0;
        mem_mask      = '0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (ls_acc) begin
            mem_we    = ls_req_we;
            mem_mask  = ls_req_mask;
            mem_addr  = ls_req_addr;
            mem_wdata = ls_req_wdata;
        end else if (if_acc) begin
            mem_mask  = {MASK_W{1'b1}};
            mem_addr  = if_req_addr;
        end
    end

    // Arbitration history moves only on an accepted request.
    always_comb begin
        last_grant_d = last_grant_q;
        if (ls_acc) begin
            last_grant_d = OWN_LS;
        end else if (if_acc) begin
            last_grant_d = OWN_IF;
        end
    end

    // Tag pipeline: stage 0 takes the new access, older tags shift along.
    // A flush kills IF tags as they move; the request accepted in the flush
    // cycle enters stage 0 untouched and survives.
    always_comb begin
        for (int i = 0; i < MEM_LATENCY; i++) begin
            tag_d[i] = '0;
        end
        tag_d[0].valid    = if_acc || ls_acc;
        tag_d[0].owner    = ls_acc ? OWN_LS : OWN_IF;
        tag_d[0].is_write = ls_acc && ls_req_we;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
            if (if_flush && (tag_q[i-1].owner == OWN_IF)) begin
                tag_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_grant_q <= OWN_IF;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign exit_tag = tag_q[MEM_LATENCY-1];

    // The exiting tag pairs with this cycle's mem_rdata. An IF tag exiting
    // during a flush is suppressed here since it never shifts again.
    always_comb begin
        if_rsp_valid = exit_tag.valid && (exit_tag.owner == OWN_IF) && !if_flush;
        ls_rsp_valid = exit_tag.valid && (exit_tag.owner == OWN_LS);
        if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
        ls_rsp_data  = (ls_rsp_valid && !exit_tag.is_write) ? mem_rdata : '0;
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Two-master arbiter placed between the pipeline and a single-port, fixed-latency memory.
- It replaces the zero-latency unified instruction/data memory hookup with valid/ready request channels for instruction fetch (IF) and load/store (LS).
- Each in-flight read is tracked by a tag pipeline, so every response returns to its owner.
- An IF flush discards stale fetch responses after a redirect.

Parameters:
- DATA_WIDTH, 32: data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32: byte address width.
- MEM_LATENCY, 1: cycles from downstream request to mem_rdata valid; legal range 1..8.
- DATA_PRIORITY, 1: 1 = LS always wins a conflict; 0 = round-robin.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch accepted this cycle (combinational).
- if_req_addr  in  ADDR_WIDTH  fetch address.
- if_flush  in  1  kill all in-flight fetch responses.
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_data  out  DATA_WIDTH  fetched instruction.
- ls_req_valid  in  1  load/store request.
- ls_req_ready  out  1  load/store accepted (combinational).
- ls_req_we  in  1  1 = store.
- ls_req_mask  in  DATA_WIDTH/8  byte enables.
- ls_req_addr  in  ADDR_WIDTH  address.
- ls_req_wdata  in  DATA_WIDTH  store data.
- ls_rsp_valid  out  1  load data or store acknowledge.
- ls_rsp_data  out  DATA_WIDTH  load data; 0 for a store acknowledge.
- mem_req_valid  out  1  downstream access this cycle.
- mem_we  out  1  downstream write.
- mem_mask  out  DATA_WIDTH/8  downstream byte enables.
- mem_addr  out  ADDR_WIDTH  downstream address.
- mem_wdata  out  DATA_WIDTH  downstream write data.
- mem_rdata  in  DATA_WIDTH  read data, valid MEM_LATENCY cycles after request.

Behaviour:
- Downstream memory always accepts. At most one grant per cycle.
- Handshake: a request is accepted when valid && ready in the same cycle.
  - Requesters hold address/data stable until accepted.
  - Ready never depends on the requester's own valid.
- Grant rule:
  - Only one master valid: it gets ready=1.
  - Both valid, DATA_PRIORITY=1: LS granted, if_req_ready=0.
  - Both valid, DATA_PRIORITY=0: the master not granted last is granted.
  - last_grant register updates only on an accepted request; reset value is IF, so LS wins the first conflict.
- Downstream mux is combinational from the grant:
  - mem_req_valid = accepted.
  - IF grant drives mem_we=0 and mem_mask=all ones.
  - No grant drives mem_we=0 and mem_mask=0.
- Tag pipeline: MEM_LATENCY stages, each holding {valid, owner, is_write}.
  - Stage 0 is loaded on accept; tags shift every cycle.
  - A tag exiting the last stage generates exactly one response, using mem_rdata of that cycle.
- Responses: owner IF gives if_rsp_valid=1 and if_rsp_data=mem_rdata. Owner LS gives ls_rsp_valid=1, with ls_rsp_data=mem_rdata for a load or 0 for a store.
- Responses cannot be stalled; the requester must accept them.
- Response data outputs are 0 whenever the matching rsp_valid is 0.
- Ordering: responses return in acceptance order per master. Total latency from accept to response is exactly MEM_LATENCY cycles.
- Flush:
  - if_flush=1 clears the valid bit of every IF tag currently in the pipeline, including one exiting this cycle.
  - An IF request accepted in the flush cycle is kept.
  - LS tags are unaffected.
- Reset, asynchronous: all tags invalid, last_grant=IF. Responses are 0; ready outputs follow the combinational grant.
- Reset deassertion mid-transaction: in-flight reads are discarded and no response is produced.

Test Plan:
- MEM_LATENCY=1, IF fetch addr 0x0 with mem holding 0x00500093 -> if_rsp_valid one cycle after accept, data 0x00500093.
- DATA_PRIORITY=1, IF and LS load both valid for 3 cycles -> LS granted first cycle; IF stalled (ready=0) until LS drops; responses keep their owners.
- DATA_PRIORITY=0, both valid continuously for 4 cycles -> grants alternate LS, IF, LS, IF.
- LS store addr 0x10, mask 4'b0011, wdata 0xDEADBEEF -> mem_we=1, mem_mask=4'b0011; ls_rsp_valid after MEM_LATENCY with data 0. Then a load of 0x10 returns 0x0000BEEF.
- MEM_LATENCY=3, three back-to-back fetches, if_flush asserted the cycle after the third accept, with a new fetch accepted in the flush cycle -> zero responses for the first three; one response for the new fetch.
- Assert arst_n=0 with 2 reads in flight (MEM_LATENCY=3) -> no rsp_valid during or after reset; first post-reset conflict is granted to LS.
